pmodkypd_scanner: RTL
=====================

PMODKYPD_SCANNER -- requirements
Module: pmodkypd_scanner

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1000, cycles a column is driven before rows are sampled; legal range 4..65535.
REQ-002 Parameter DEBOUNCE_FRAMES, default 4, consecutive identical scan frames required to accept a keymap change; legal range 1..255.
REQ-003 Port clk  in  1  single clock; all state on its rising edge.
REQ-004 Port rst  in  1  reset, asynchronous, active-high.
REQ-005 Port enable  in  1  scan enable; low pauses scanning and releases all columns.
REQ-006 Ports col_tri_t / col_tri_o  out  4 each  GPIO master to Pmod bridge top row (keypad columns, bit n = COL n+1).
REQ-007 Port col_tri_i  in  4  top-row readback; unused.
REQ-008 Ports row_tri_t / row_tri_o  out  4 each  GPIO master to Pmod bridge bottom row (keypad rows).
REQ-009 Port row_tri_i  in  4  keypad row levels, asynchronous, low = pressed.
REQ-010 Port keys  out  16  debounced keymap, bit index = key code (1 = held).
REQ-011 Ports key_valid out 1 / key_code out 4 / key_ready in 1  press-event stream, valid/ready handshake.
REQ-012 Ports overflow out 1 / overflow_clr in 1  sticky lost-event flag and its clear.

Function
REQ-013 row_tri_t SHALL be 4'hF and row_tri_o 4'h0 at all times (rows are inputs).
REQ-014 Undriven columns: col_tri_t bit = 1; driven column: col_tri_t bit = 0, col_tri_o bit = 0; col_tri_o SHALL always be 4'h0.
REQ-015 row_tri_i SHALL pass a 2-flop synchronizer before any use.
REQ-016 FSM states IDLE, DRIVE, SAMPLE; column index c 0..3; settle counter.
REQ-017 IDLE: all columns released; enable=1 -> DRIVE with c=0, counter cleared.
REQ-018 DRIVE: drive column c for exactly SETTLE_CYCLES cycles, then -> SAMPLE.
REQ-019 SAMPLE (1 cycle): frame bits for column c := ~synced rows; c<3 -> DRIVE c+1; c=3 -> frame complete, DRIVE c=0.
REQ-020 Frame period SHALL be 4*(SETTLE_CYCLES+1) cycles.
REQ-021 enable=0 in any state -> IDLE next cycle; partial frame discarded; keys, stability count, event register retained.
REQ-022 Key code of (column c, row r): fixed table, col1 rows1-4 = 1,4,7,0; col2 = 2,5,8,F; col3 = 3,6,9,E; col4 = A,B,C,D.
REQ-023 At frame complete: frame equals previous frame -> stability count increments (saturating at DEBOUNCE_FRAMES); else count := 1 and previous := frame.
REQ-024 When count reaches DEBOUNCE_FRAMES and frame differs from keys, keys := frame on the following cycle.
REQ-025 On a keys update, newly set bits (new & ~old) SHALL raise one event: the lowest set code; other simultaneous new presses are dropped without setting overflow.
REQ-026 Releases SHALL update keys but never raise an event.
REQ-027 Event with key_valid=0, or key_valid=1 and key_ready=1 that cycle: key_code := code, key_valid=1.
REQ-028 Event with key_valid=1 and key_ready=0: held event retained unchanged, overflow := 1.
REQ-029 key_valid=1 and key_ready=1 with no new event: key_valid := 0; key_code SHALL hold while key_valid=1.
REQ-030 overflow_clr=1 clears overflow; simultaneous overflow set wins.

Reset
REQ-031 rst=1 SHALL asynchronously force: FSM IDLE, c=0, counters 0, synchronizers 4'hF, previous frame 0, keys 16'h0, key_valid 0, key_code 4'h0, overflow 0, col_tri_t 4'hF.
REQ-032 After deassertion scanning starts from column 0 at the first edge with enable=1; reset mid-frame discards all partial data.

Structure
REQ-033 Shared package pmodkypd_pkg SHALL hold the state encoding, the 4x4 code table and the number of rows/columns.
REQ-034 One sub-module, pmodkypd_sync2 (4-bit 2-flop synchronizer, reset value 4'hF).

Verification (SETTLE_CYCLES=4, DEBOUNCE_FRAMES=2, frame = 20 cycles)
REQ-035 Reset then enable=1, no keys -> col_tri_t cycles E,D,B,7 each held 5 cycles; keys=0; key_valid never 1.
REQ-036 Hold col2/row3 -> keys=16'h0100 within 3 frames, one event key_code=8, key_valid held until key_ready=1.
REQ-037 Glitch col1/row1 for one frame only -> keys and key_valid unchanged.
REQ-038 Press 5 (key_ready=0) then release and press 9 -> key_code stays 5, overflow=1; overflow_clr -> 0.
REQ-039 Press 1 and C in same frame -> single event key_code=1, keys=16'h1002.
REQ-040 Assert rst mid-DRIVE col3 with key held -> all outputs at REQ-031 values immediately; rescan from column 0.

Source files
------------

// File: rtl/pmodkypd_pkg.sv
// Shared constants for the Pmod KYPD scanner: state encoding, keypad geometry, code table.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package pmodkypd_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2
  } scan_state_t;

  // Key code printed on the keypad at (column, row), both zero-based.
  function automatic logic [3:0] code_of(input logic [1:0] col, input logic [1:0] row);
    logic [3:0] code;
    case ({col, row})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h4;
      4'b00_10: code = 4'h7;
      4'b00_11: code = 4'h0;
      4'b01_00: code = 4'h2;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h8;
      4'b01_11: code = 4'hF;
      4'b10_00: code = 4'h3;
      4'b10_01: code = 4'h6;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hE;
      4'b11_00: code = 4'hA;
      4'b11_01: code = 4'hB;
      4'b11_10: code = 4'hC;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  // Lowest key code whose bit is set; 0 when the map is empty.
  function automatic logic [3:0] lowest_code(input logic [15:0] map);
    logic [3:0] code;
    code = 4'h0;
    for (int i = 15; i >= 0; i--) begin
      if (map[i]) code = 4'(i);
    end
    return code;
  endfunction

endpackage

// File: rtl/pmodkypd_sync2.sv
// Two-flop synchronizer for the asynchronous keypad row inputs (idle-high reset value).
// Latency: 2 clk cycles from input change to output.
// Backpressure: none; samples every cycle.
module pmodkypd_sync2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_d,
  output logic [3:0] o_q
);

  logic [3:0] r_meta;
  logic [3:0] r_sync;

  // Two register stages; rows idle high so reset to all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 4'hF;
      r_sync <= 4'hF;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pmodkypd_scanner.sv
// Column-scanning Pmod KYPD driver with frame debouncing and a one-deep press-event stream.
// Latency: frame = 4*(SETTLE_CYCLES+1) cycles; keymap accepted DEBOUNCE_FRAMES frames after a change, +1 cycle.
// Backpressure: key_ready low holds the pending event; further presses are dropped and flag overflow.
module pmodkypd_scanner
  import pmodkypd_pkg::*;
#(
  parameter int SETTLE_CYCLES   = 1000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [3:0]  col_tri_t,
  output logic [3:0]  col_tri_o,
  input  logic [3:0]  col_tri_i,
  output logic [3:0]  row_tri_t,
  output logic [3:0]  row_tri_o,
  input  logic [3:0]  row_tri_i,
  output logic [15:0] keys,
  output logic        key_valid,
  output logic [3:0]  key_code,
  input  logic        key_ready,
  output logic        overflow,
  input  logic        overflow_clr
);

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [7:0]  DEB_TARGET  = 8'(DEBOUNCE_FRAMES);
  localparam logic [1:0]  LAST_COL    = 2'(NUM_COLS - 1);

  scan_state_t r_state;
  logic [1:0]  r_col;
  logic [15:0] r_settle_cnt;
  logic [3:0]  r_col_t;
  logic [15:0] r_frame;
  logic [15:0] r_prev;
  logic [7:0]  r_stab;
  logic [15:0] r_keys;
  logic        r_key_vld;
  logic [3:0]  r_key_code;
  logic        r_ovf;

  logic [3:0]  w_rows_sync;
  logic [1:0]  w_col_nxt;
  logic [15:0] w_frame_full;
  logic        w_frame_done;
  logic        w_keys_upd;
  logic [15:0] w_new_keys;
  logic        w_event;
  logic        w_unused;

  // Column readback is not needed: the keypad only ever pulls rows.
  assign w_unused = ^col_tri_i;

  pmodkypd_sync2 u_row_sync (
    .clk (clk),
    .rst (rst),
    .i_d (row_tri_i),
    .o_q (w_rows_sync)
  );

  assign w_col_nxt    = r_col + 2'd1;
  assign w_frame_done = enable && (r_state == ST_SAMPLE) && (r_col == LAST_COL);

  // Complete frame as it will look once the last column's rows are folded in.
  always_comb begin
    w_frame_full = r_frame;
    for (int r = 0; r < NUM_ROWS; r++) begin
      w_frame_full[code_of(LAST_COL, 2'(r))] = ~w_rows_sync[r];
    end
  end

  // Scan FSM: drive one column low, let it settle, sample rows, move on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_col        <= 2'd0;
      r_settle_cnt <= 16'd0;
      r_col_t      <= 4'hF;
      r_frame      <= 16'h0;
    end else if (!enable) begin
      r_state      <= ST_IDLE;
      r_col        <= 2'd0;
      r_settle_cnt <= 16'd0;
      r_col_t      <= 4'hF;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state      <= ST_DRIVE;
          r_col        <= 2'd0;
          r_settle_cnt <= 16'd0;
          r_col_t      <= 4'hE;
        end
        ST_DRIVE: begin
          if (r_settle_cnt == SETTLE_LAST) begin
            r_state      <= ST_SAMPLE;
            r_settle_cnt <= 16'd0;
          end else begin
            r_settle_cnt <= r_settle_cnt + 16'd1;
          end
        end
        ST_SAMPLE: begin
          for (int r = 0; r < NUM_ROWS; r++) begin
            r_frame[code_of(r_col, 2'(r))] <= ~w_rows_sync[r];
          end
          r_state <= ST_DRIVE;
          r_col   <= w_col_nxt;
          r_col_t <= ~(4'b0001 << w_col_nxt);
        end
        default: begin
          r_state <= ST_IDLE;
          r_col_t <= 4'hF;
        end
      endcase
    end
  end

  // Debounce: count consecutive identical frames, restart on any difference.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= 16'h0;
      r_stab <= 8'd0;
    end else if (w_frame_done) begin
      if (w_frame_full == r_prev) begin
        if (r_stab != DEB_TARGET) r_stab <= r_stab + 8'd1;
      end else begin
        r_stab <= 8'd1;
        r_prev <= w_frame_full;
      end
    end
  end

  assign w_keys_upd = (r_stab == DEB_TARGET) && (r_prev != r_keys);
  assign w_new_keys = r_prev & ~r_keys;
  assign w_event    = w_keys_upd && (|w_new_keys);

  // Accept the stable frame and emit at most one press event (lowest new code).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_keys     <= 16'h0;
      r_key_vld  <= 1'b0;
      r_key_code <= 4'h0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_keys_upd) r_keys <= r_prev;

      if (w_event && (!r_key_vld || key_ready)) begin
        r_key_vld  <= 1'b1;
        r_key_code <= lowest_code(w_new_keys);
      end else if (r_key_vld && key_ready) begin
        r_key_vld <= 1'b0;
      end

      // A lost event outranks a clear in the same cycle.
      if (w_event && r_key_vld && !key_ready) begin
        r_ovf <= 1'b1;
      end else if (overflow_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign col_tri_t = r_col_t;
  assign col_tri_o = 4'h0;
  assign row_tri_t = 4'hF;
  assign row_tri_o = 4'h0;
  assign keys      = r_keys;
  assign key_valid = r_key_vld;
  assign key_code  = r_key_code;
  assign overflow  = r_ovf;

endmodule
